// File: rtl/mem_access_unit.sv
// Data-memory access unit: one load/store per Avalon-style bus transaction, with byte-lane
// steering and load extension. Define MEM_ACCESS_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // MIPS I load/store opcodes
    localparam logic [OP_W-1:0] OPCODE_LB  = 6'h20;
    localparam logic [OP_W-1:0] OPCODE_LH  = 6'h21;
    localparam logic [OP_W-1:0] OPCODE_LW  = 6'h23;
    localparam logic [OP_W-1:0] OPCODE_LBU = 6'h24;
    localparam logic [OP_W-1:0] OPCODE_LHU = 6'h25;
    localparam logic [OP_W-1:0] OPCODE_SB  = 6'h28;
    localparam logic [OP_W-1:0] OPCODE_SH  = 6'h29;
    localparam logic [OP_W-1:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [OP_W-1:0]     op_q;
    logic [1:0]          lane_q;

    logic                is_load_c;
    logic                is_store_c;
    logic                is_byte_c;
    logic                is_half_c;
    logic                misalign_c;
    logic                accept_c;
    logic                rd_done_c;
    logic [BE_W-1:0]     be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [7:0]          rd_byte_c;
    logic [15:0]         rd_half_c;
    logic [DATA_W-1:0]   ext_c;

    // Request decode
    always_comb begin
        is_load_c  = 1'b0;
        is_store_c = 1'b0;
        is_byte_c  = 1'b0;
        is_half_c  = 1'b0;
        unique case (opcode)
            OPCODE_LB, OPCODE_LBU: begin is_load_c  = 1'b1; is_byte_c = 1'b1; end
            OPCODE_LH, OPCODE_LHU: begin is_load_c  = 1'b1; is_half_c = 1'b1; end
            OPCODE_LW:             begin is_load_c  = 1'b1; end
            OPCODE_SB:             begin is_store_c = 1'b1; is_byte_c = 1'b1; end
            OPCODE_SH:             begin is_store_c = 1'b1; is_half_c = 1'b1; end
            OPCODE_SW:             begin is_store_c = 1'b1; end
            default:               ;
        endcase
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    always_comb begin
        misalign_c = 1'b0;
        if (is_half_c)
            misalign_c = addr[0];
        else if (!is_byte_c)
            misalign_c = (addr[1:0] != 2'b00);
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Byte-lane steering; stores replicate the datum across all lanes
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        if (is_byte_c) begin
            be_c    = 4'b0001 << addr[1:0];
            wdata_c = {4{store_data[7:0]}};
        end else if (is_half_c) begin
            be_c    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{store_data[15:0]}};
        end
    end

    assign accept_c  = start && ((state_q == IDLE) || (state_q == DONE)) && (is_load_c || is_store_c);
    assign rd_done_c = (state_q == READ) && !avm_waitrequest;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE)
                    state_d = IDLE;
                if (accept_c) begin
                    if (misalign_c)
                        state_d = DONE;
                    else if (is_load_c)
                        state_d = READ;
                    else
                        state_d = WRITE;
                end
            end
            READ, WRITE: begin
                if (!avm_waitrequest)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load extraction from the lane captured at accept
    always_comb begin
        unique case (lane_q)
            2'd0:    rd_byte_c = avm_readdata[7:0];
            2'd1:    rd_byte_c = avm_readdata[15:8];
            2'd2:    rd_byte_c = avm_readdata[23:16];
            default: rd_byte_c = avm_readdata[31:24];
        endcase
        rd_half_c = lane_q[1] ? avm_readdata[31:16] : avm_readdata[15:0];
        ext_c     = avm_readdata;
        unique case (op_q)
            OPCODE_LB:  ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
            OPCODE_LBU: ext_c = {24'h000000, rd_byte_c};
            OPCODE_LH:  ext_c = {{16{rd_half_c[15]}}, rd_half_c};
            OPCODE_LHU: ext_c = {16'h0000, rd_half_c};
            default:    ext_c = avm_readdata;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            op_q           <= '0;
            lane_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            misaligned     <= 1'b0;
            load_data      <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d == READ) || (state_d == WRITE);
            avm_read   <= (state_d == READ);
            avm_write  <= (state_d == WRITE);
            done       <= (state_d == DONE);
            misaligned <= accept_c && misalign_c;
            if (accept_c) begin
                op_q           <= opcode;
                lane_q         <= addr[1:0];
                avm_address    <= {addr[31:2], 2'b00};
                avm_byteenable <= be_c;
                avm_writedata  <= wdata_c;
            end
            if (rd_done_c)
                load_data <= ext_c;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: lane steering, load extension, wait states,
// back-to-back requests, reset mid-transaction and the optional alignment trap.
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int total = 0;
    int bad   = 0;

    mem_access_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .store_data      (store_data),
        .busy            (busy),
        .done            (done),
        .load_data       (load_data),
        .misaligned      (misaligned),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, hold it across one rising edge, then drop start
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start      = 1'b1;
        opcode     = op;
        addr       = a;
        store_data = d;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Zero-wait load: check the read strobe cycle, then the done cycle
    task automatic load_test(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] rd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_ld);
        avm_readdata    = rd;
        avm_waitrequest = 1'b0;
        issue(op, a, 32'h0);
        @(negedge clk);
        check({tag, "_read"}, 32'(avm_read), 32'd1);
        check({tag, "_addr"}, avm_address, exp_addr);
        check({tag, "_be"}, 32'(avm_byteenable), 32'(exp_be));
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_data"}, load_data, exp_ld);
    endtask

    initial begin
        reset_n         = 1'b0;
        start           = 1'b0;
        opcode          = '0;
        addr            = '0;
        store_data      = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ld", load_data, 32'h0);
        check("rst_rdwr", {30'd0, avm_read, avm_write}, 32'd0);
        reset_n = 1'b1;

        load_test("lb",   OP_LB,  32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
        @(negedge clk);
        check("lb_done_pulse", 32'(done), 32'd0);
        load_test("lbu",  OP_LBU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0000_0080);
        load_test("lh2",  OP_LH,  32'h0000_2002, 32'h7F01_8000, 32'h0000_2000, 4'b1100, 32'h0000_7F01);
        load_test("lh0",  OP_LH,  32'h0000_2000, 32'h7F01_8000, 32'h0000_2000, 4'b0011, 32'hFFFF_8000);
        load_test("lhu0", OP_LHU, 32'h0000_2000, 32'h7F01_8000, 32'h0000_2000, 4'b0011, 32'h0000_8000);
        load_test("lb1",  OP_LB,  32'h0000_2001, 32'h7F01_8000, 32'h0000_2000, 4'b0010, 32'hFFFF_FF80);

        // Halfword store with three wait states; load_data must keep the last load
        avm_waitrequest = 1'b1;
        issue(OP_SH, 32'h0000_3002, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sh_write", 32'(avm_write), 32'd1);
            check("sh_busy", 32'(busy), 32'd1);
            check("sh_wdata", avm_writedata, 32'hBEEF_BEEF);
            check("sh_be", 32'(avm_byteenable), 32'h0000_000C);
            check("sh_nodone", 32'(done), 32'd0);
            if (i == 3)
                avm_waitrequest = 1'b0;
        end
        @(negedge clk);
        check("sh_done", 32'(done), 32'd1);
        check("sh_wr_low", 32'(avm_write), 32'd0);
        check("sh_ld_kept", load_data, 32'hFFFF_FF80);

        // SB then LW back-to-back, second start presented during done
        avm_readdata = 32'h1234_5678;
        issue(OP_SB, 32'h0000_0010, 32'h0000_00AB);
        @(negedge clk);
        check("sb_write", 32'(avm_write), 32'd1);
        check("sb_wdata", avm_writedata, 32'hABAB_ABAB);
        check("sb_be", 32'(avm_byteenable), 32'h0000_0001);
        @(negedge clk);
        check("sb_done", 32'(done), 32'd1);
        start  = 1'b1;
        opcode = OP_LW;
        addr   = 32'h0000_0020;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_read", 32'(avm_read), 32'd1);
        check("b2b_nodone", 32'(done), 32'd0);
        check("b2b_addr", avm_address, 32'h0000_0020);
        check("b2b_be", 32'(avm_byteenable), 32'h0000_000F);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_data", load_data, 32'h1234_5678);

        // Unknown opcode in IDLE is ignored
        @(negedge clk);
        issue(6'h00, 32'h0000_0F00, 32'h0);
        @(negedge clk);
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_rdwr", {30'd0, avm_read, avm_write}, 32'd0);
        check("ign_addr", avm_address, 32'h0000_0020);
        check("ign_done", 32'(done), 32'd0);

        // Misaligned word load
        avm_readdata = 32'hA5A5_5A5A;
        issue(OP_LW, 32'h0000_4001, 32'h0);
        @(negedge clk);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        check("mis_noread", 32'(avm_read), 32'd0);
        check("mis_done", 32'(done), 32'd1);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_ld_kept", load_data, 32'h1234_5678);
`else
        check("mis_read", 32'(avm_read), 32'd1);
        check("mis_addr", avm_address, 32'h0000_4000);
        check("mis_be", 32'(avm_byteenable), 32'h0000_000F);
        @(negedge clk);
        check("mis_done", 32'(done), 32'd1);
        check("mis_flag", 32'(misaligned), 32'd0);
        check("mis_data", load_data, 32'hA5A5_5A5A);
`endif

        // Reset in the middle of a stalled read
        @(negedge clk);
        avm_waitrequest = 1'b1;
        issue(OP_LW, 32'h0000_5000, 32'h0);
        @(negedge clk);
        check("mid_read", 32'(avm_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_read", 32'(avm_read), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ld", load_data, 32'h0);
        check("mid_rst_addr", avm_address, 32'h0);
        @(negedge clk);
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        load_test("post_rst", OP_LW, 32'h0000_6000, 32'hCAFE_F00D, 32'h0000_6000, 4'b1111, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
